// File: rtl/fetch_decode_stage.sv
// Fetch stage and IF/ID pipeline register of the RV32I core.
// Holds the PC, applies the Execute redirect, registers the fetched word into
// Decode and keeps saturating stall/flush event counters.
module fetch_decode_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             PCSrcE,
  input  logic [31:0]      PCTargetE,
  input  logic [31:0]      InstrF,
  output logic [31:0]      PCF,
  output logic [31:0]      InstrD,
  output logic [31:0]      PCD,
  output logic [31:0]      PCPlus4D,
  output logic             ValidD,
  output logic [4:0]       Rs1D,
  output logic [4:0]       Rs2D,
  output logic [4:0]       RdD,
  output logic             MisalignF,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  // Sequential fetch address; wraps modulo 2^32 with no flag.
  logic [31:0] pcPlus4_p0;
  assign pcPlus4_p0 = PCF + 32'd4;

  // Fetch stage (p0): redirect beats stall so a taken branch is never lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      PCF       <= RESET_PC;
      MisalignF <= 1'b0;
    end else begin
      if (PCSrcE) begin
        PCF <= {PCTargetE[31:2], 2'b00};
      end else if (!StallF) begin
        PCF <= pcPlus4_p0;
      end
      if (PCSrcE && (PCTargetE[1:0] != 2'b00)) begin
        MisalignF <= 1'b1;
      end
    end
  end

  // IF/ID boundary (p1): flush beats stall; a flush leaves PCD/PCPlus4D stale.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD   <= NOP_INSTR;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      InstrD   <= InstrF;
      PCD      <= PCF;
      PCPlus4D <= pcPlus4_p0;
      ValidD   <= 1'b1;
    end
  end

  // Performance counters: count raw StallF/FlushD cycles, independent of redirect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallF) StallCnt <= satInc(StallCnt);
      if (FlushD) FlushCnt <= satInc(FlushCnt);
    end
  end

  // Decode register indices, gated so a bubble never looks like a real source.
  assign Rs1D = ValidD ? InstrD[19:15] : 5'd0;
  assign Rs2D = ValidD ? InstrD[24:20] : 5'd0;
  assign RdD  = ValidD ? InstrD[11:7]  : 5'd0;

endmodule

// File: doc/fetch_decode_stage.md
Name: fetch_decode_stage

Overview:
Fetch stage and IF/ID pipeline register of the 5-stage RV32I core. The block holds the PC, computes PC+4, and applies the Execute-stage redirect. It drives the instruction-memory address, registers the fetched word into Decode, and extracts the Decode register indices consumed by the hazard unit. It obeys StallF/StallD/FlushD from the hazard unit and keeps saturating stall/flush event counters for performance debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble inserted into InstrD on reset/flush (addi x0,x0,0)
CNT_W, 16, width of each performance counter

Ports:
clk  input  1  core clock; all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
StallF  input  1  hold PC register
StallD  input  1  hold IF/ID register
FlushD  input  1  replace IF/ID contents with bubble
PCSrcE  input  1  branch/jump taken in Execute; redirect PC
PCTargetE  input  32  redirect target from Execute
InstrF  input  32  instruction word from imem (combinational read of PCF)
PCF  output  32  current fetch address to imem
InstrD  output  32  registered instruction in Decode
PCD  output  32  PC of InstrD
PCPlus4D  output  32  PCD+4
ValidD  output  1  InstrD is a real fetched instruction (0 = bubble)
Rs1D  output  5  InstrD[19:15], forced 0 when ValidD=0
Rs2D  output  5  InstrD[24:20], forced 0 when ValidD=0
RdD  output  5  InstrD[11:7], forced 0 when ValidD=0
MisalignF  output  1  sticky: a redirect target had [1:0]!=0
StallCnt  output  CNT_W  cycles with StallF=1 (saturating)
FlushCnt  output  CNT_W  cycles with FlushD=1 (saturating)

Behaviour:
- Reset (rst_n=0 at posedge): PCF=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, MisalignF=0, StallCnt=0, FlushCnt=0. Reset overrides every other input, including mid-stall and mid-flush.
- PCPlus4F = PCF+4, modulo 2^32. 32'hFFFF_FFFC wraps to 0 with no flag.
- PC next-state priority:
  - PCSrcE=1 -> PCF <= {PCTargetE[31:2],2'b00}.
  - else StallF=1 -> hold.
  - else PCF <= PCPlus4F.
  - A redirect always wins over a stall, so a taken branch is never lost.
- MisalignF sets when PCSrcE=1 and PCTargetE[1:0]!=0. It stays set until reset.
- IF/ID register priority:
  - FlushD=1 -> InstrD=NOP_INSTR, ValidD=0; PCD and PCPlus4D hold their old values (don't-care).
  - else StallD=1 -> hold all IF/ID fields.
  - else InstrD=InstrF, PCD=PCF, PCPlus4D=PCPlus4F, ValidD=1.
- Latency: an instruction at PCF in cycle N appears in InstrD in cycle N+1 when unstalled.
- Redirect timing: PCSrcE in cycle N gives PCF=target in N+1. The target instruction reaches InstrD in N+2. The wrong-path word fetched in N is squashed by FlushD in N.
- Rs1D/Rs2D/RdD are combinational from InstrD, gated to 0 when ValidD=0 so bubbles never cause a false load-use stall.
- Counters:
  - StallCnt += 1 on each cycle with StallF=1; FlushCnt += 1 on each cycle with FlushD=1.
  - Both saturate at all-ones; no wrap.
  - Counting is independent of PCSrcE priority.
- No internal state machine beyond the registers above. The first cycle after reset release fetches RESET_PC; ValidD rises one cycle later.

Test Plan:
- Reset/sequential: rst_n low 2 cycles, release, imem returns PC-indexed words -> PCF = 0,4,8,C on successive cycles; InstrD follows one cycle later; ValidD=0 first cycle, then 1; all outputs at reset values while rst_n=0.
- Load-use stall: StallF=StallD=1 for one cycle with PCF=0x10 -> PCF stays 0x10 and InstrD holds the word from 0x0C; next cycle PCF=0x14; StallCnt=1.
- Taken branch: PCSrcE=1, PCTargetE=0x100, FlushD=1 at PCF=0x20 -> next cycle PCF=0x100, InstrD=0x00000013, ValidD=0, Rs1D=Rs2D=RdD=0; cycle after, InstrD=mem[0x100], PCD=0x100; FlushCnt=1.
- Simultaneous redirect and stall: PCSrcE=1, StallF=1, StallD=1, FlushD=1, PCTargetE=0x40 -> PCF=0x40 next cycle and InstrD=bubble (flush beats stall).
- Misaligned target and wrap: PCTargetE=0x102 -> PCF=0x100 and MisalignF=1, still 1 after 10 cycles; separately force PCF=0xFFFFFFFC unstalled -> next PCF=0x0.
- Counter saturation and reset mid-stall: CNT_W=4, hold StallF=1 for 20 cycles -> StallCnt=15 and stays 15; assert rst_n=0 during the stall -> next cycle StallCnt=0, PCF=RESET_PC.
